ip_switch_sequencer: RTL and testbench

//  Sequences run-time IP selection for the multi-IP top: filters the raw ip_sel pad

---
 rtl/ip_switch_sequencer.sv | 148 ++++++++++++++
 tb/tb_ip_switch_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ip_switch_sequencer.sv
// Run-time IP selection sequencer: filters the pad select, then switches the pad mux
// and per-IP resets in the order isolate -> hold resets -> select -> release -> de-isolate.
module ip_switch_sequencer #(
  parameter int NUM_IP          = 8,
  parameter int STABLE_CYCLES   = 16,
  parameter int ISO_CYCLES      = 4,
  parameter int RST_HOLD_CYCLES = 32,
  localparam int SEL_W          = (NUM_IP > 1) ? $clog2(NUM_IP) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [SEL_W-1:0]  active_sel_o,
  output logic [NUM_IP-1:0] ip_rst_o,
  output logic              pad_iso_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int MAX_A = (ISO_CYCLES > RST_HOLD_CYCLES) ? ISO_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_C = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] ISO_END  = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [SEL_W:0]   NUM_IP_V = (SEL_W + 1)'(NUM_IP);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_ISOLATE,
    S_HOLD,
    S_RELEASE
  } state_t;

  logic [SEL_W-1:0]  r_sync1;
  logic [SEL_W-1:0]  r_sel_s;
  logic [SEL_W-1:0]  r_sel_q;
  logic [CNT_W-1:0]  r_scnt;
  logic [CNT_W-1:0]  r_tcnt;
  logic [SEL_W-1:0]  r_active;
  logic              r_done;
  state_t            r_state;

  state_t            w_state_nxt;
  logic              w_load_sel;
  logic              w_done_nxt;
  logic              w_iso;
  logic [NUM_IP-1:0] w_rst;
  logic [NUM_IP-1:0] w_rst_run;
  logic              w_stable;
  logic              w_inrange;
  logic              w_req;

  // Two-flop synchronizer followed by the stability filter on the select value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sel_s <= '0;
      r_sel_q <= '0;
      r_scnt  <= '0;
    end else begin
      r_sync1 <= sel_i;
      r_sel_s <= r_sync1;
      if (r_sel_s != r_sel_q) begin
        r_sel_q <= r_sel_s;
        r_scnt  <= '0;
      end else if (r_scnt != STABLE_C) begin
        r_scnt  <= r_scnt + 1'b1;
      end
    end
  end

  assign w_stable  = (r_scnt == STABLE_C);
  assign w_inrange = ({1'b0, r_sel_q} < NUM_IP_V);
  assign w_req     = w_stable && w_inrange && (r_sel_q != r_active);
  assign w_rst_run = ~(NUM_IP'(1) << r_active);

  // State register; the phase counter restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_BOOT;
      r_tcnt   <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load_sel)
        r_active <= r_sel_q;
      if (w_state_nxt != r_state)
        r_tcnt <= '0;
      else if (r_state == S_ISOLATE || r_state == S_HOLD || r_state == S_RELEASE)
        r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_sel  = 1'b0;
    w_done_nxt  = 1'b0;
    w_iso       = 1'b1;
    w_rst       = '1;
    case (r_state)
      S_BOOT: begin
        if (w_stable && w_inrange) begin
          w_state_nxt = S_HOLD;
          w_load_sel  = 1'b1;
        end
      end
      S_IDLE: begin
        w_iso = 1'b0;
        w_rst = w_rst_run;
        if (w_req)
          w_state_nxt = S_ISOLATE;
      end
      S_ISOLATE: begin
        w_rst = w_rst_run;
        if (r_tcnt == ISO_END) begin
          w_state_nxt = S_HOLD;
          w_load_sel  = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_tcnt == HOLD_END)
          w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_rst = w_rst_run;
        if (r_tcnt == ISO_END) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  assign active_sel_o = r_active;
  assign ip_rst_o     = w_rst;
  assign pad_iso_o    = w_iso;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign err_o        = w_stable && !w_inrange;

endmodule

// File: tb/tb_ip_switch_sequencer.sv
// Directed bench for ip_switch_sequencer: default 8-IP instance plus a 6-IP instance
// for out-of-range select handling.
module tb_ip_switch_sequencer;

  logic       clock;
  logic       reset;
  logic       reset6;
  logic [2:0] sel_i;
  logic [2:0] active_sel;
  logic [7:0] ip_rst;
  logic       pad_iso, busy, done, err;
  logic [2:0] sel6;
  logic [2:0] active6;
  logic [5:0] ip_rst6;
  logic       iso6, busy6, done6, err6;

  int n_vec  = 0;
  int n_miss = 0;

  ip_switch_sequencer u_dut (
    .clock(clock), .reset(reset), .sel_i(sel_i), .active_sel_o(active_sel),
    .ip_rst_o(ip_rst), .pad_iso_o(pad_iso), .busy_o(busy), .done_o(done), .err_o(err)
  );

  ip_switch_sequencer #(.NUM_IP(6)) u_dut6 (
    .clock(clock), .reset(reset6), .sel_i(sel6), .active_sel_o(active6),
    .ip_rst_o(ip_rst6), .pad_iso_o(iso6), .busy_o(busy6), .done_o(done6), .err_o(err6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] rst_of(input int d);
    return (d == 0) ? ip_rst : {2'b00, ip_rst6};
  endfunction

  function automatic logic iso_of(input int d);
    return (d == 0) ? pad_iso : iso6;
  endfunction

  task automatic wait_rst(input int d, output int n);
    logic [7:0] v0;
    v0 = rst_of(d);
    n = 0;
    do begin
      tick();
      n++;
    end while (rst_of(d) == v0 && n < 200);
  endtask

  task automatic wait_iso(input int d, input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (iso_of(d) != v && n < 200);
  endtask

  initial begin
    int n;
    int c_iso, c_busy, c_rst, c_done;
    reset  = 1'b1;
    reset6 = 1'b1;
    sel_i  = 3'd1;
    sel6   = 3'd7;
    repeat (3) tick();

    // Reset state
    chk("rst_active", active_sel, 0);
    chk("rst_iprst",  ip_rst, 8'hFF);
    chk("rst_iso",    pad_iso, 1);
    chk("rst_busy",   busy, 1);
    chk("rst_done",   done, 0);
    chk("rst_err",    err, 0);

    // 1: boot onto IP 1
    reset = 1'b0;
    wait_rst(0, n);
    chk("boot_lat",    n, 52);
    chk("boot_rst",    ip_rst, 8'hFD);
    chk("boot_active", active_sel, 1);
    chk("boot_iso_rel", pad_iso, 1);
    wait_iso(0, 1'b0, n);
    chk("boot_iso_lat", n, 4);
    chk("boot_done",    done, 1);
    chk("boot_busy",    busy, 0);
    tick();
    chk("boot_done_end", done, 0);

    // 2: switch 1 -> 3
    sel_i = 3'd3;
    wait_iso(0, 1'b1, n);
    chk("sw3_iso_lat",  n, 20);
    chk("sw3_iso_rst",  ip_rst, 8'hFD);
    wait_rst(0, n);
    chk("sw3_isolate",  n, 4);
    chk("sw3_hold_rst", ip_rst, 8'hFF);
    chk("sw3_active",   active_sel, 3);
    wait_rst(0, n);
    chk("sw3_hold_len", n, 32);
    chk("sw3_rst",      ip_rst, 8'hF7);
    wait_iso(0, 1'b0, n);
    chk("sw3_rel_len",  n, 4);
    chk("sw3_done",     done, 1);
    tick();
    chk("sw3_done_end", done, 0);

    // 3: short glitch to 5 then back -> no switch
    c_iso = 0; c_busy = 0; c_rst = 0; c_done = 0;
    sel_i = 3'd5;
    for (int i = 0; i < 70; i++) begin
      if (i == 10) sel_i = 3'd3;
      tick();
      c_iso  += int'(pad_iso);
      c_busy += int'(busy);
      c_done += int'(done);
      if (ip_rst != 8'hF7) c_rst++;
    end
    chk("glitch_iso",  c_iso, 0);
    chk("glitch_busy", c_busy, 0);
    chk("glitch_rst",  c_rst, 0);
    chk("glitch_done", c_done, 0);
    chk("glitch_act",  active_sel, 3);

    // 4: switch 3 -> 1, select moves to 2 during HOLD
    sel_i = 3'd1;
    wait_iso(0, 1'b1, n);
    chk("sw1_iso_lat", n, 20);
    wait_rst(0, n);
    chk("sw1_isolate", n, 4);
    repeat (2) tick();
    sel_i = 3'd2;
    wait_rst(0, n);
    chk("sw1_hold_len", n, 30);
    chk("sw1_rst",      ip_rst, 8'hFD);
    chk("sw1_active",   active_sel, 1);
    wait_iso(0, 1'b0, n);
    chk("sw1_rel_len",  n, 4);
    chk("sw1_done",     done, 1);
    tick();
    chk("sw2_restart_iso",  pad_iso, 1);
    chk("sw2_restart_busy", busy, 1);
    chk("sw2_restart_done", done, 0);
    wait_rst(0, n);
    chk("sw2_isolate", n, 4);
    wait_rst(0, n);
    chk("sw2_hold_len", n, 32);
    chk("sw2_rst",      ip_rst, 8'hFB);
    chk("sw2_active",   active_sel, 2);
    wait_iso(0, 1'b0, n);
    chk("sw2_rel_len",  n, 4);
    chk("sw2_done",     done, 1);

    // 5: six-IP instance, out-of-range select
    reset6 = 1'b0;
    repeat (40) tick();
    chk("e_boot_err",  err6, 1);
    chk("e_boot_busy", busy6, 1);
    chk("e_boot_rst",  ip_rst6, 6'h3F);
    chk("e_boot_iso",  iso6, 1);
    sel6 = 3'd1;
    wait_rst(1, n);
    chk("e_boot_lat",  n, 52);
    chk("e_boot_err0", err6, 0);
    chk("e_rst1",      ip_rst6, 6'h3D);
    wait_iso(1, 1'b0, n);
    chk("e_rel_len",   n, 4);
    chk("e_done",      done6, 1);
    sel6 = 3'd7;
    repeat (40) tick();
    chk("e_idle_err",  err6, 1);
    chk("e_idle_iso",  iso6, 0);
    chk("e_idle_busy", busy6, 0);
    chk("e_idle_rst",  ip_rst6, 6'h3D);
    chk("e_idle_act",  active6, 1);
    sel6 = 3'd2;
    wait_iso(1, 1'b1, n);
    chk("e_sw_lat",    n, 20);
    chk("e_sw_err",    err6, 0);
    wait_rst(1, n);
    chk("e_isolate",   n, 4);
    wait_rst(1, n);
    chk("e_hold_len",  n, 32);
    chk("e_rst2",      ip_rst6, 6'h3B);
    chk("e_act2",      active6, 2);
    wait_iso(1, 1'b0, n);
    chk("e_rel2_len",  n, 4);

    // 6: reset pulsed mid-HOLD on the main instance
    sel_i = 3'd4;
    wait_iso(0, 1'b1, n);
    chk("r_iso_lat", n, 20);
    wait_rst(0, n);
    chk("r_hold_rst", ip_rst, 8'hFF);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("r_active", active_sel, 0);
    chk("r_iprst",  ip_rst, 8'hFF);
    chk("r_iso",    pad_iso, 1);
    chk("r_busy",   busy, 1);
    chk("r_done",   done, 0);
    chk("r_err",    err, 0);
    repeat (2) tick();
    reset = 1'b0;
    wait_rst(0, n);
    chk("r_boot_lat", n, 52);
    chk("r_boot_rst", ip_rst, 8'hEF);
    chk("r_boot_act", active_sel, 4);
    wait_iso(0, 1'b0, n);
    chk("r_rel_len",  n, 4);
    chk("r_done_end", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
